// File: rtl/fpu_uart_pkg.sv
// Shared UART definitions for the FPU serial link (receiver and result
// transmitter).
//   UART_DATA_BITS    : data bits per 8N1 frame
//   UART_CLKS_PER_BIT : default baud divider (10 MHz / 115200)
//   uart_state_e      : common UART state encoding
package fpu_uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_e;

endpackage

// File: rtl/fpu_result_uart_tx_if.sv
// Word handshake between the FPU FSM top and the result transmitter.
//   i_result : result word offered by the FPU
//   i_valid  : i_result is valid
//   o_ready  : transmitter can accept a word (accept = i_valid && o_ready)
interface fpu_result_uart_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] i_result;
    logic              i_valid;
    logic              o_ready;

    modport master (
        output i_result,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_result,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/uart_tx_byte.sv
// Per-byte 8N1 transmit engine: start bit, 8 data bits LSB first, stop bit.
//   clk, rst     : clock, synchronous active-high reset
//   i_byte       : byte to send, latched when a frame starts
//   i_start      : start a frame (taken in IDLE, or on the last stop-bit
//                  cycle so consecutive bytes have no idle gap)
//   o_byte_done  : high on the last cycle of the stop bit
//   o_tx_serial  : serial line, driven straight from a flop
//
// state | meaning
// IDLE  | line high, waiting for i_start
// START | line low for one bit time
// DATA  | line = r_byte[r_bit], r_bit 0..7
// STOP  | line high for one bit time; may chain straight into START
module uart_tx_byte
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] i_byte,
    input  logic                      i_start,
    output logic                      o_byte_done,
    output logic                      o_tx_serial
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_state_e               r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [BIT_W-1:0]          r_bit, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_byte, w_byte_nxt;
    logic                      r_tx, w_tx_nxt;
    logic                      w_bit_end;
    logic [BIT_W-1:0]          w_bit_inc;

    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_bit_inc   = r_bit + BIT_W'(1);
    assign o_tx_serial = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_tx_nxt    = r_tx;
        o_byte_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt  = 1'b1;
                w_cnt_nxt = '0;
                if (i_start) begin
                    w_state_nxt = START;
                    w_byte_nxt  = i_byte;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_byte[0];
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = r_byte[w_bit_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    o_byte_done = 1'b1;
                    w_cnt_nxt   = '0;
                    // Chaining here removes the idle cycle between bytes.
                    if (i_start) begin
                        w_state_nxt = START;
                        w_byte_nxt  = i_byte;
                        w_bit_nxt   = '0;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fpu_result_uart_tx.sv
// Result return path: sends each accepted 16-bit FPU result as two 8N1
// frames, high byte first, with no gap between the two frames.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : word handshake (slave side: i_result, i_valid, o_ready)
//   o_tx_serial : UART TX line, idles high
//   o_busy      : word transfer in progress (~o_ready)
//   o_done      : one-cycle pulse after the second stop bit
//
// state   | meaning
// IDLE    | ready for a word, line high
// DATA    | byte engine sending byte r_byte_idx of r_word
// CLEANUP | one cycle, o_done pulse, not ready
module fpu_result_uart_tx
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_result_uart_tx_if.slave  bus,
    output logic                 o_tx_serial,
    output logic                 o_busy,
    output logic                 o_done
);

    uart_state_e               r_state, w_state_nxt;
    logic [DATA_W-1:0]         r_word, w_word_nxt;
    logic                      r_byte_idx, w_byte_idx_nxt;
    logic                      w_start;
    logic [UART_DATA_BITS-1:0] w_byte;
    logic                      w_byte_done;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk         (clk),
        .rst         (rst),
        .i_byte      (w_byte),
        .i_start     (w_start),
        .o_byte_done (w_byte_done),
        .o_tx_serial (o_tx_serial)
    );

    assign bus.o_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == CLEANUP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_byte_idx <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_byte_idx <= w_byte_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_word_nxt     = r_word;
        w_byte_idx_nxt = r_byte_idx;
        w_start        = 1'b0;
        w_byte         = '0;
        case (r_state)
            IDLE: begin
                if (bus.i_valid) begin
                    // High byte goes straight from the port so the start
                    // bit appears the cycle after acceptance.
                    w_state_nxt    = DATA;
                    w_word_nxt     = bus.i_result;
                    w_byte_idx_nxt = 1'b0;
                    w_start        = 1'b1;
                    w_byte         = bus.i_result[DATA_W-1 -: UART_DATA_BITS];
                end
            end
            DATA: begin
                if (w_byte_done) begin
                    if (!r_byte_idx) begin
                        w_byte_idx_nxt = 1'b1;
                        w_start        = 1'b1;
                        w_byte         = r_word[UART_DATA_BITS-1:0];
                    end else begin
                        w_state_nxt = CLEANUP;
                    end
                end
            end
            CLEANUP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
module tb_fpu_result_uart_tx;

    localparam int CPB = 4;
    localparam int NB  = 20 * CPB;

    localparam int M_NORM     = 0;
    localparam int M_HOLD     = 1;
    localparam int M_SCRAMBLE = 2;
    localparam int M_BUSY     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_tx_serial, o_busy, o_done;

    fpu_result_uart_tx_if #(.DATA_W(16)) bus();

    fpu_result_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_tx_serial (o_tx_serial),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level for 8N1 bit slot j (0..19) of a word, high byte first.
    function automatic logic slot_level(input logic [15:0] w, input int j);
        logic [7:0] b;
        int p;
        b = (j < 10) ? w[15:8] : w[7:0];
        p = j % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    function automatic logic [NB-1:0] exp_wave(input logic [15:0] w);
        logic [NB-1:0] v;
        for (int k = 0; k < NB; k++) v[k] = slot_level(w, k / CPB);
        return v;
    endfunction

    // Receiver model: sample mid-bit of each data bit.
    function automatic logic [7:0] rx_decode(input logic [NB-1:0] wv, input int n);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = wv[(10*n + 1 + i)*CPB + CPB/2];
        return b;
    endfunction

    task automatic run_word(input logic [15:0] w, input int mode,
                            output int acc_cyc, output int done_cyc);
        logic [NB-1:0] wv;
        int to;
        int bad_done;
        wv = '0;
        bad_done = 0;
        done_cyc = -1;
        acc_cyc = -1;
        bus.i_result = w;
        bus.i_valid  = 1'b1;
        to = 0;
        while (!bus.o_ready && to < 300) begin
            @(negedge clk);
            to++;
        end
        check_val("ready_wait", (to < 300), 1'b1);
        @(posedge clk);
        for (int k = 0; k < NB + 2; k++) begin
            @(negedge clk);
            if (k < NB) wv[k] = o_tx_serial;
            if (o_done && k != NB) bad_done++;
            if (k == 0) acc_cyc = cyc;
            if (k == NB/2) check_val("busy_mid", {o_busy, bus.o_ready}, 2'b10);
            if (k == NB) begin
                check_val("done_pulse", {o_done, o_tx_serial, bus.o_ready}, 3'b110);
                done_cyc = cyc;
            end
            if (k == NB + 1) check_val("ready_after", {bus.o_ready, o_tx_serial, o_busy}, 3'b110);
            if (k == 0 && mode != M_HOLD) bus.i_valid = 1'b0;
            if (mode == M_SCRAMBLE && k < NB) bus.i_result = 16'($urandom);
            if (mode == M_BUSY && k == 30) begin
                bus.i_result = 16'hC000;
                bus.i_valid  = 1'b1;
            end
            if (mode == M_BUSY && k == 31) bus.i_valid = 1'b0;
        end
        check_val("wave", wv, exp_wave(w));
        check_val("rx_hi", rx_decode(wv, 0), w[15:8]);
        check_val("rx_lo", rx_decode(wv, 1), w[7:0]);
        check_val("no_early_done", bad_done, 0);
    endtask

    // Watch an idle line: no done, line high, ready high.
    task automatic watch_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_done || !o_tx_serial || !bus.o_ready) bad++;
        end
        check_val(tag, bad, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, d1, a2, d2;
        logic [15:0] rw;
        bus.i_result = '0;
        bus.i_valid  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", {o_tx_serial, bus.o_ready, o_busy, o_done}, 4'b1100);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_reset_idle", {o_tx_serial, bus.o_ready, o_busy, o_done}, 4'b1100);

        // bf16 1.0
        run_word(16'h3F80, M_NORM, a1, d1);
        check_val("done_latency", d1 - a1, NB);

        // Busy rejection: mid-frame C000 must be dropped.
        run_word(16'h4049, M_BUSY, a1, d1);
        watch_idle("busy_reject_idle", 3 * NB);

        // Back-to-back with i_valid held.
        run_word(16'h0001, M_HOLD, a1, d1);
        run_word(16'hFFFF, M_NORM, a2, d2);
        check_val("b2b_accept_gap", a2 - a1, NB + 2);
        check_val("b2b_done_gap", d2 - d1, NB + 2);

        // Reset during byte 0 data bit 3 (0x34 bit 3 = 0, so line is low).
        bus.i_result = 16'h3400;
        bus.i_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (17) @(negedge clk);
        check_val("pre_reset_line", o_tx_serial, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midframe_reset", {o_tx_serial, bus.o_ready, o_done}, 3'b110);
        rst = 1'b0;
        watch_idle("abort_no_done", 3 * NB);
        run_word(16'h1234, M_NORM, a1, d1);

        // Input changes after acceptance must not leak onto the line.
        run_word(16'hA5A5, M_SCRAMBLE, a1, d1);
        bus.i_valid = 1'b0;
        watch_idle("scramble_idle", 4);

        for (int i = 0; i < 6; i++) begin
            rw = 16'($urandom);
            run_word(rw, M_NORM, a1, d1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_result_uart_tx.md
# fpu_result_uart_tx

Serial return path for the bfloat16 FPU: takes each 16-bit `FPU_hp_result` word produced by the FPU FSM top and transmits it on a UART TX line as two 8N1 frames, high byte first. It sits beside the existing UART receiver inside the FPU top, so the host that sends operands over the RX pin reads results back on a TX pin at the same baud rate. It also drives a GPIO pad in the user project wrapper.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per serial bit, matching the receiver (10 MHz / 115200). Must be at least 2.
- `DATA_W`, default 16: result word width. Fixed at 16; two bytes per word.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_result` in 16: FPU result word to transmit.
- `i_valid` in 1: `i_result` is valid. The word is accepted when `i_valid && o_ready`.
- `o_ready` in/out: out 1. The block can accept a word. High only in IDLE.
- `o_tx_serial` out 1: UART line. Idles high.
- `o_busy` out 1: a frame pair is in progress (`~o_ready`).
- `o_done` out 1: one-cycle pulse after the second stop bit completes.

## Operation
- 8N1 framing, LSB first:
  - start bit = 0;
  - 8 data bits;
  - stop bit = 1;
  - no parity.
- Byte 0 is `i_result[15:8]`. Byte 1 is `i_result[7:0]`. No idle gap between the byte-0 stop bit and the byte-1 start bit.
- On acceptance, the word is latched into a 16-bit holding register. Later changes on `i_result` have no effect.
- States:
  - IDLE: `o_tx_serial`=1, `o_ready`=1. On accept, go to START and set byte index = 0.
  - START: line 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index = 0.
  - DATA: line = current byte bit[bit index] for `CLKS_PER_BIT` cycles. The bit index increments 0..7; after bit 7, go to STOP.
  - STOP: line 1 for `CLKS_PER_BIT` cycles. At the end of the stop bit:
    - if byte index = 0, set byte index = 1 and go to START;
    - otherwise go to CLEANUP.
  - CLEANUP: one cycle, line 1, `o_done`=1, `o_ready`=0. Go to IDLE.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and clears on every state or bit change. Its width is $clog2(`CLKS_PER_BIT`).
- `i_valid` while not ready is ignored. No queueing; the upstream holds the word until it sees `o_ready`.
- Reset values: state = IDLE; `o_tx_serial`=1; `o_ready`=1; `o_busy`=0; `o_done`=0; all counters and the holding register = 0.
- Reset mid-frame aborts the transfer. The next cycle shows line=1 and `o_ready`=1, and no `o_done` pulse is produced.

## Timing
- Accept in cycle T. The start bit begins at T+1 (registered output, no combinational path from `i_valid` to `o_tx_serial`).
- Each bit lasts exactly `CLKS_PER_BIT` cycles. Byte 1 starts at T+1+10·`CLKS_PER_BIT`.
- The second stop bit ends at T+20·`CLKS_PER_BIT`.
- `o_done` is high at T+1+20·`CLKS_PER_BIT`. `o_ready` is high from T+2+20·`CLKS_PER_BIT`.
- Back-to-back words: if the next word is accepted on the first ready cycle, there is one idle-high cycle (the CLEANUP cycle) plus the accept cycle between frames. Minimum word period is 20·`CLKS_PER_BIT`+2 cycles.
- Line glitches are forbidden: `o_tx_serial` comes straight from a flop.

## Structure
- Shared package `fpu_uart_pkg`, shared with the receiver:
  - state enum (IDLE, START, DATA, STOP, CLEANUP);
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`.
- One sub-module, `uart_tx_byte`: the per-byte START/DATA/STOP engine with `i_byte`/`i_start`/`o_byte_done`.
- The top, `fpu_result_uart_tx`, sequences the two bytes and owns the word handshake and `o_done`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset: assert `rst` 2 cycles → `o_tx_serial`=1, `o_ready`=1, `o_busy`=0, `o_done`=0.
- Single word 16'h3F80 (bf16 1.0), accepted at T:
  - line from T+1, in 4-cycle bits: 0,1,1,1,1,1,1,0,0,1, then 0,0,0,0,0,0,0,0,1,1;
  - `o_done` at T+81;
  - a receiver model decodes 0x3F then 0x80.
- Busy rejection: pulse `i_valid` with 16'hC000 mid-frame of 16'h4049 → only 0x40, 0x49 are sent, and no second `o_done`.
- Back-to-back: hold `i_valid` with 16'h0001 then 16'hFFFF → bytes 0x00, 0x01, 0xFF, 0xFF. Exactly 2 line-high cycles between the two word frames; two `o_done` pulses 82 cycles apart.
- Reset mid-frame: assert `rst` during the DATA bit 3 of byte 0 → the next cycle shows line=1 and `o_ready`=1, with no `o_done`. A new word 16'h1234 then transmits cleanly.
- Input hold: change `i_result` every cycle after accepting 16'hA5A5 → the line still carries 0xA5, 0xA5.
